// File: rtl/vec_mem_stage.sv
// Vector memory stage: serialises per-lane loads/stores onto a scalar req/ack
// memory port, gathers load data into a lane vector and stalls the pipeline meanwhile.
module vec_mem_stage #(
   parameter int N     = 16,
   parameter int LANES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MemReadM,
   input  logic                 MemWriteM,
   input  logic [LANES-1:0]     LaneMaskM,
   input  logic [LANES*N-1:0]   AluResultM,
   input  logic [LANES*N-1:0]   WriteDataM,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [N-1:0]         mem_addr,
   output logic [N-1:0]         mem_wdata,
   input  logic                 mem_ack,
   input  logic [N-1:0]         mem_rdata,
   output logic [LANES*N-1:0]   ReadDataM,
   output logic                 StallM,
   output logic                 DoneM
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [LANES*N-1:0]   addr_buf;
   logic [LANES*N-1:0]   data_buf;
   logic [LANES*N-1:0]   rd_buf;
   logic [LANES*N-1:0]   rd_merged;
   logic [LANES-1:0]     mask_buf;
   logic                 op_wr;
   logic                 req_in;
   logic                 last_lane;
   logic [CW-1:0]        next_lane;

   function automatic logic [CW-1:0] lowest_set(input logic [LANES-1:0] m);
      lowest_set = '0;
      for (int i = LANES - 1; i >= 0; i--)
         if (m[i]) lowest_set = CW'(i);
   endfunction

   function automatic logic [CW-1:0] next_set(input logic [LANES-1:0] m, input logic [CW-1:0] c);
      next_set = c;
      for (int i = LANES - 1; i >= 0; i--)
         if (m[i] && (i > int'(c))) next_set = CW'(i);
   endfunction

   function automatic logic any_above(input logic [LANES-1:0] m, input logic [CW-1:0] c);
      any_above = 1'b0;
      for (int i = 0; i < LANES; i++)
         if (m[i] && (i > int'(c))) any_above = 1'b1;
   endfunction

   assign req_in    = MemReadM | MemWriteM;
   assign next_lane = next_set(mask_buf, cnt);
   assign last_lane = ~any_above(mask_buf, cnt);

   // Load buffer with the lane being acknowledged this cycle folded in, so the
   // final lane lands in ReadDataM on the same edge that enters DONE.
   always_comb begin
      rd_merged = rd_buf;
      rd_merged[int'(cnt)*N +: N] = mem_rdata;
   end

   // The accept cycle stalls combinationally; otherwise everything comes from state/buffers.
   assign StallM    = rst_n & ((state == ACCESS) | ((state == IDLE) & req_in));
   assign mem_req   = (state == ACCESS);
   assign mem_we    = mem_req & op_wr;
   assign mem_addr  = mem_req ? addr_buf[int'(cnt)*N +: N] : '0;
   assign mem_wdata = mem_req ? data_buf[int'(cnt)*N +: N] : '0;
   assign DoneM     = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_buf  <= '0;
         data_buf  <= '0;
         rd_buf    <= '0;
         mask_buf  <= '0;
         op_wr     <= 1'b0;
         ReadDataM <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_in) begin
                  addr_buf <= AluResultM;
                  data_buf <= WriteDataM;
                  mask_buf <= LaneMaskM;
                  op_wr    <= MemWriteM;
                  cnt      <= lowest_set(LaneMaskM);
                  rd_buf   <= '0;
                  if (LaneMaskM == '0) begin
                     state <= DONE;
                     if (!MemWriteM) ReadDataM <= '0;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (!op_wr) rd_buf <= rd_merged;
                  if (last_lane) begin
                     state <= DONE;
                     if (!op_wr) ReadDataM <= rd_merged;
                  end else begin
                     cnt <= next_lane;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed table-driven bench for vec_mem_stage with a behavioural req/ack
// memory that returns 0xA000+addr and can insert wait states on one address.
module tb_vec_mem_stage;
   localparam int N     = 16;
   localparam int LANES = 16;
   localparam int W     = N * LANES;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           MemReadM, MemWriteM;
   logic [LANES-1:0] LaneMaskM;
   logic [W-1:0]   AluResultM, WriteDataM;
   logic           mem_req, mem_we;
   logic [N-1:0]   mem_addr, mem_wdata;
   logic           mem_ack = 1'b0;
   logic [N-1:0]   mem_rdata = '0;
   logic [W-1:0]   ReadDataM;
   logic           StallM, DoneM;

   always #5 clk = ~clk;

   vec_mem_stage #(.N(N), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .LaneMaskM(LaneMaskM), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
      .StallM(StallM), .DoneM(DoneM)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0] addr;
      logic         we;
      logic [N-1:0] wdata;
   } bus_t;

   bus_t         bus_q[$];
   logic [N-1:0] wait_addr = 16'hFFFF;
   int           wait_n = 0;
   int           hold = 0;
   int           unstable = 0;
   logic         pend = 1'b0;
   logic [N-1:0] p_addr = '0, p_wdata = '0;
   logic         p_we = 1'b0;

   // Memory model: decides the ack for the coming edge and logs completed accesses.
   always @(negedge clk) begin
      if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
         unstable++;
      if (mem_req) begin
         if (mem_addr == wait_addr && hold < wait_n) begin
            mem_ack = 1'b0;
            hold++;
         end else begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hA000 + mem_addr;
            hold      = 0;
            bus_q.push_back('{mem_addr, mem_we, mem_wdata});
         end
      end else begin
         mem_ack = 1'b0;
         hold    = 0;
      end
      pend    = mem_req && !mem_ack;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
   end

   typedef struct {
      logic         rd;
      logic         wr;
      logic [15:0]  mask;
      logic [15:0]  abase;
      logic [W-1:0] wdata;
      logic [15:0]  waddr;
      int           wn;
      int           exp_stall;
      int           exp_reqs;
   } vec_t;

   vec_t         vecs[6];
   logic [W-1:0] exp_rd = '0;

   function automatic logic [W-1:0] mk_wdata(input logic [15:0] base);
      logic [W-1:0] w;
      for (int i = 0; i < LANES; i++) w[i*N +: N] = base + 16'(i) * 16'h0101;
      return w;
   endfunction

   task automatic clear_inputs();
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      LaneMaskM  = '0;
      AluResultM = '0;
      WriteDataM = '0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int stalls;
      int guard;
      int k;
      bus_q.delete();
      unstable  = 0;
      wait_addr = v.waddr;
      wait_n    = v.wn;
      @(negedge clk);
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      LaneMaskM  = v.mask;
      WriteDataM = v.wdata;
      for (int i = 0; i < LANES; i++) AluResultM[i*N +: N] = v.abase + 16'(i);
      #1;
      stalls = 0;
      guard  = 0;
      while (StallM === 1'b1 && guard < 200) begin
         stalls++;
         guard++;
         @(negedge clk);
         #1;
      end
      chk({tag, " stall_bounded"}, W'(guard < 200), W'(1));
      chk({tag, " stall_cycles"}, W'(stalls), W'(v.exp_stall));
      chk({tag, " done_pulse"}, W'(DoneM), W'(1));
      chk({tag, " bus_cycles"}, W'(bus_q.size()), W'(v.exp_reqs));
      chk({tag, " held_stable"}, W'(unstable), W'(0));
      k = 0;
      for (int i = 0; i < LANES; i++) begin
         if (v.mask[i]) begin
            if (k < bus_q.size()) begin
               chk($sformatf("%s addr%0d", tag, k), W'(bus_q[k].addr), W'(v.abase + 16'(i)));
               chk($sformatf("%s we%0d", tag, k), W'(bus_q[k].we), W'(v.wr));
               if (v.wr) chk($sformatf("%s wdata%0d", tag, k), W'(bus_q[k].wdata), W'(v.wdata[i*N +: N]));
            end
            k++;
         end
      end
      if (v.rd && !v.wr) begin
         exp_rd = '0;
         for (int i = 0; i < LANES; i++)
            if (v.mask[i]) exp_rd[i*N +: N] = 16'hA000 + v.abase + 16'(i);
      end
      chk({tag, " read_data"}, ReadDataM, exp_rd);
      clear_inputs();
      @(negedge clk);
      #1;
      chk({tag, " done_drop"}, W'(DoneM), W'(0));
      chk({tag, " idle_stall"}, W'(StallM), W'(0));
      chk({tag, " idle_req"}, W'(mem_req), W'(0));
      chk({tag, " read_hold"}, ReadDataM, exp_rd);
   endtask

   initial begin
      logic [W-1:0] sw;
      vec_t         clean;
      int           guard;

      sw = '0;
      sw[15:0]    = 16'h1234;
      sw[255:240] = 16'hBEEF;
      vecs[0] = '{1'b1, 1'b0, 16'hFFFF, 16'h0100, mk_wdata(16'h0000), 16'hFFFF, 0, 17, 16};
      vecs[1] = '{1'b0, 1'b1, 16'h8001, 16'h0180, sw,                 16'hFFFF, 0,  3,  2};
      vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0200, mk_wdata(16'h0000), 16'h0202, 3, 12,  8};
      vecs[3] = '{1'b1, 1'b1, 16'h0003, 16'h0300, mk_wdata(16'h5000), 16'hFFFF, 0,  3,  2};
      vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0400, mk_wdata(16'h0000), 16'hFFFF, 0,  1,  0};
      vecs[5] = '{1'b1, 1'b0, 16'h0A50, 16'h3000, mk_wdata(16'h0000), 16'hFFFF, 0,  5,  4};
      clean   = '{1'b1, 1'b0, 16'hFFFF, 16'h0500, mk_wdata(16'h0000), 16'hFFFF, 0, 17, 16};

      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      MemReadM  = 1'b1;
      LaneMaskM = 16'hFFFF;
      #1;
      chk("reset mem_req", W'(mem_req), W'(0));
      chk("reset stall", W'(StallM), W'(0));
      chk("reset done", W'(DoneM), W'(0));
      chk("reset addr", W'(mem_addr), W'(0));
      chk("reset read_data", ReadDataM, '0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run_vec(vecs[t], $sformatf("v%0d", t));

      // Abort a load with an asynchronous reset while lane 5 is on the bus.
      @(negedge clk);
      MemReadM  = 1'b1;
      LaneMaskM = 16'hFFFF;
      for (int i = 0; i < LANES; i++) AluResultM[i*N +: N] = 16'h0400 + 16'(i);
      guard = 0;
      #1;
      while (!(mem_req === 1'b1 && mem_addr === 16'h0405) && guard < 40) begin
         guard++;
         @(negedge clk);
         #1;
      end
      chk("rst_mid reached_lane5", W'(guard < 40), W'(1));
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid mem_req", W'(mem_req), W'(0));
      chk("rst_mid stall", W'(StallM), W'(0));
      chk("rst_mid done", W'(DoneM), W'(0));
      chk("rst_mid read_data", ReadDataM, '0);
      exp_rd = '0;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst stall", W'(StallM), W'(0));
      chk("post_rst mem_req", W'(mem_req), W'(0));
      run_vec(clean, "post_rst_load");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_mem_stage.md
Name: vec_mem_stage

Overview:
- Memory stage of the vector pipeline. Directly downstream of the execute stage.
- Consumes the 16-lane ALU result (per-lane addresses) and the 16-lane forwarded store data after the EX/MEM register.
- Serialises them into one-lane-at-a-time accesses on a scalar 16-bit data-memory port with a req/ack handshake, and gathers load data back into a 16-lane vector.
- Holds the pipeline with StallM until every enabled lane has completed.

Parameters:
- N, 16, lane width in bits (address and data).
- LANES, 16, number of vector lanes.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- MemReadM  in  1  vector load request; held by the EX/MEM register while StallM=1.
- MemWriteM  in  1  vector store request; held the same way.
- LaneMaskM  in  LANES  per-lane enable; bit i=1 means lane i is accessed.
- AluResultM  in  LANES*N  per-lane memory addresses, lane i at [i].
- WriteDataM  in  LANES*N  per-lane store data.
- mem_req  out  1  scalar memory request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  N  scalar address.
- mem_wdata  out  N  scalar write data.
- mem_ack  in  1  memory completes the current access this cycle.
- mem_rdata  in  N  read data; valid when mem_ack=1 on a read.
- ReadDataM  out  LANES*N  gathered load vector.
- StallM  out  1  freeze IF/ID/EX and the EX/MEM register.
- DoneM  out  1  one-cycle pulse when a vector access finishes.

Behaviour:
- Reset: async, active-low. While rst_n=0, all of the following are 0: state=IDLE, lane counter, address/data/mask buffers, ReadDataM, mem_req, mem_we, mem_addr, mem_wdata, StallM, DoneM.
- Reset mid-operation: aborts immediately. mem_req drops asynchronously. No partial ReadDataM update survives.
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - If MemReadM|MemWriteM, the request is accepted.
  - StallM=1 combinationally in the same cycle.
  - On the clock edge: capture AluResultM, WriteDataM, LaneMaskM and the op (write if MemWriteM=1, otherwise read) into internal buffers.
  - Load the counter with the lowest set mask bit.
  - If LaneMaskM==0, go to DONE with no bus cycles; otherwise go to ACCESS.
  - With no request: StallM=0, stay in IDLE.
- Simultaneous MemReadM and MemWriteM: treated as a write; ReadDataM is not modified.
- ACCESS:
  - mem_req=1, mem_we=op, mem_addr=addr_buf[cnt], mem_wdata=data_buf[cnt].
  - StallM=1. All outputs are driven from registers/state only, never from inputs.
  - Without mem_ack, hold all signals stable, for any number of cycles.
  - On mem_ack with a read: rd_buf[cnt] <= mem_rdata.
  - On mem_ack: advance cnt to the next higher set mask bit. If there is none, go to DONE.
  - Masked-off lanes get no bus cycle.
  - On a read, masked-off lanes of the result are 0.
- DONE:
  - StallM=0, DoneM=1 for exactly one cycle, mem_req=0.
  - Read: ReadDataM <= assembled buffer on entry to DONE, so it is visible in the DONE cycle.
  - Requests are ignored in DONE, because the EX/MEM register advances at the end of this cycle.
  - Next state is IDLE.
- ReadDataM holds its last load result through stores and idle cycles. It updates only when a load completes.
- mem_ack outside ACCESS is ignored.
- Latency with k enabled lanes and zero-wait memory:
  - StallM is high for k+1 cycles: the accept cycle plus k ACCESS cycles.
  - DoneM follows in the next cycle.
  - With an all-zero mask, StallM is high for 1 cycle.
- Address/data width: no arithmetic; lanes pass through unchanged.
- The counter is $clog2(LANES) bits wide and never wraps past LANES-1.

Test Plan:
- Load, full mask, zero-wait: AluResultM lane i = 0x0100+i, memory returns 0xA000+addr, LaneMaskM=0xFFFF -> 16 mem_req cycles with addresses 0x0100..0x010F in order; StallM high for 17 cycles; DoneM pulse; ReadDataM lane i = 0xA100+i.
- Store, sparse mask: LaneMaskM=0x8001, WriteDataM lane0=0x1234, lane15=0xBEEF -> exactly 2 write cycles (lane0 then lane15, mem_we=1); ReadDataM unchanged from the prior load; StallM high for 3 cycles.
- Wait states: load with mem_ack delayed 3 cycles on lane 2 -> mem_addr/mem_req stable for those cycles; lane order preserved; correct final ReadDataM; StallM extends by 3 cycles.
- Empty mask: MemReadM=1, LaneMaskM=0 -> no mem_req; StallM high for 1 cycle; DoneM next cycle; ReadDataM=0 in all lanes.
- Read+write together: both strobes set, mask 0x0003 -> two write cycles; ReadDataM untouched.
- Reset mid-ACCESS: drop rst_n during lane 5 of a load -> mem_req, StallM, DoneM and ReadDataM go to 0 immediately. After release, stays IDLE; a new load runs cleanly from lane 0.
